free_list: RTL and testbench

- Circular FIFO of free physical register IDs for the out-of-order core.
- The dispatch side pops one physical destination register per renamed instruction that writes rd != x0.
- The ROB commit side pushes back the superseded physical register of each retiring instruction.
- On a pipeline flush, every speculatively allocated register is recovered in one cycle.

---
 rtl/free_list_pkg.sv | 20 ++
 rtl/free_list.sv | 106 ++++++++++
 tb/tb_free_list.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/free_list_pkg.sv
// Shared parameters and pointer type for the physical-register free list.
package free_list_pkg;

  localparam int unsigned P_WIDTH   = 6;
  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned N_PHYS    = 2 ** P_WIDTH;
  localparam int unsigned FL_DEPTH  = N_PHYS - ARCH_REGS;
  localparam int unsigned FL_PTR_W  = $clog2(FL_DEPTH);
  localparam int unsigned FL_PTR_LEN = FL_PTR_W + 1;

  typedef struct packed {
    logic                wrap;
    logic [FL_PTR_W-1:0] idx;
  } fl_ptr_t;

  function automatic fl_ptr_t ptr_inc(input fl_ptr_t p);
    return fl_ptr_t'(FL_PTR_LEN'(p) + FL_PTR_LEN'(1));
  endfunction

endpackage

// File: rtl/free_list.sv
// Circular free list of physical register IDs with single-cycle flush recovery.
// Optional double-free checker enabled by defining FREE_LIST_CHECK_EN.
module free_list
  import free_list_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                fl_deque,
  output logic [P_WIDTH-1:0]  pd_fl,
  output logic                is_empty_fl,
  input  logic                free_enque,
  input  logic [P_WIDTH-1:0]  free_pd,
  input  logic                flush,
  output logic [FL_PTR_W:0]   fl_count,
  output logic                err_double_free
);

  if (FL_DEPTH < 2 || (FL_DEPTH & (FL_DEPTH - 1)) != 0 || ARCH_REGS >= N_PHYS) begin : g_bad_depth
    $fatal(1, "free_list: DEPTH must be a power of two and at least 2");
  end

  fl_ptr_t            head, tail, head_nxt, tail_nxt;
  logic [P_WIDTH-1:0] mem [FL_DEPTH];
  logic               full, pop_en, push_en, dbl, err_nxt;

  always_comb begin
    is_empty_fl = (head == tail);
    full        = (head.idx == tail.idx) && (head.wrap != tail.wrap);
    pd_fl       = mem[head.idx];
    fl_count    = FL_PTR_LEN'(tail - head);
  end

  // Pointer next-state: flush rebuilds a full list ending at the post-push tail.
  always_comb begin
    pop_en   = fl_deque && !is_empty_fl && !flush;
    push_en  = free_enque && !full;
    tail_nxt = push_en ? ptr_inc(tail) : tail;
    head_nxt = head;
    if (flush) begin
      head_nxt.wrap = ~tail_nxt.wrap;
      head_nxt.idx  = tail_nxt.idx;
    end else if (pop_en) begin
      head_nxt = ptr_inc(head);
    end
    err_nxt = err_double_free || (free_enque && full) || dbl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem[i] <= P_WIDTH'(ARCH_REGS + i);
      end
      head            <= '0;
      tail            <= '{wrap: 1'b1, idx: '0};
      err_double_free <= 1'b0;
    end else begin
      if (push_en) begin
        mem[tail.idx] <= free_pd;
      end
      head            <= head_nxt;
      tail            <= tail_nxt;
      err_double_free <= err_nxt;
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic [N_PHYS-1:0] in_list, in_list_nxt;

  // Membership tracking; a flush marks every slot of the now-full list as free.
  always_comb begin
    dbl         = free_enque && in_list[free_pd];
    in_list_nxt = in_list;
    if (flush) begin
      in_list_nxt = '0;
      for (int i = 0; i < FL_DEPTH; i++) begin
        if (push_en && FL_PTR_W'(i) == tail.idx) begin
          in_list_nxt[free_pd] = 1'b1;
        end else begin
          in_list_nxt[mem[i]] = 1'b1;
        end
      end
    end else begin
      if (pop_en) begin
        in_list_nxt[pd_fl] = 1'b0;
      end
      if (push_en) begin
        in_list_nxt[free_pd] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_list <= {N_PHYS{1'b1}} << ARCH_REGS;
    end else begin
      in_list <= in_list_nxt;
      if (dbl) begin
        $error("free_list: double free of physical register %0d", free_pd);
      end
    end
  end
`else
  assign dbl = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for free_list (pop/push, empty/full, flush, wrap).
module tb_free_list;
  import free_list_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                fl_deque;
  logic [P_WIDTH-1:0]  pd_fl;
  logic                is_empty_fl;
  logic                free_enque;
  logic [P_WIDTH-1:0]  free_pd;
  logic                flush;
  logic [FL_PTR_W:0]   fl_count;
  logic                err_double_free;

  int checks   = 0;
  int failures = 0;

  free_list dut (
    .clk             (clk),
    .rst             (rst),
    .fl_deque        (fl_deque),
    .pd_fl           (pd_fl),
    .is_empty_fl     (is_empty_fl),
    .free_enque      (free_enque),
    .free_pd         (free_pd),
    .flush           (flush),
    .fl_count        (fl_count),
    .err_double_free (err_double_free)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 ns after the edge.
  task automatic step(input logic deq, input logic enq, input logic [P_WIDTH-1:0] pd,
                      input logic fl);
    @(negedge clk);
    fl_deque   = deq;
    free_enque = enq;
    free_pd    = pd;
    flush      = fl;
    @(posedge clk);
    #1;
    fl_deque   = 1'b0;
    free_enque = 1'b0;
    free_pd    = '0;
    flush      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int exp_pd;
    rst = 1'b1; fl_deque = 1'b0; free_enque = 1'b0; free_pd = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pd", 32'(pd_fl), 32);
    check("rst_count", 32'(fl_count), 32);
    check("rst_empty", 32'(is_empty_fl), 0);
    check("rst_err", 32'(err_double_free), 0);
    @(negedge clk);
    rst = 1'b0;

    // Push while full is dropped and raises the sticky flag
    step(1'b0, 1'b1, 6'd40, 1'b0);
    check("full_push_err", 32'(err_double_free), 1);
    check("full_push_count", 32'(fl_count), 32);
    check("full_push_pd", 32'(pd_fl), 32);
    step(1'b1, 1'b0, '0, 1'b0);
    check("pop1_pd", 32'(pd_fl), 33);
    check("pop1_count", 32'(fl_count), 31);
    check("err_sticky", 32'(err_double_free), 1);

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pd", 32'(pd_fl), 32);
    check("async_rst_count", 32'(fl_count), 32);
    check("async_rst_err", 32'(err_double_free), 0);
    check("async_rst_empty", 32'(is_empty_fl), 0);
    @(negedge clk);
    rst = 1'b0;

    // Drain the whole list in order
    for (int i = 0; i < 32; i++) begin
      check("drain_pd", 32'(pd_fl), 32'(32 + i));
      step(1'b1, 1'b0, '0, 1'b0);
    end
    check("drain_empty", 32'(is_empty_fl), 1);
    check("drain_count", 32'(fl_count), 0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("pop_empty_empty", 32'(is_empty_fl), 1);
    check("pop_empty_count", 32'(fl_count), 0);
    check("pop_empty_pd", 32'(pd_fl), 32);

    // Empty list: pop ignored, push lands
    step(1'b1, 1'b1, 6'd45, 1'b0);
    check("empty_pp_pd", 32'(pd_fl), 45);
    check("empty_pp_count", 32'(fl_count), 1);
    check("empty_pp_empty", 32'(is_empty_fl), 0);

    // Flush recovery with a simultaneous push and (ignored) pop
    do_reset();
    for (int i = 0; i < 5; i++) begin
      check("pre_flush_pd", 32'(pd_fl), 32'(32 + i));
      step(1'b1, 1'b0, '0, 1'b0);
    end
    check("pre_flush_pd5", 32'(pd_fl), 37);
    check("pre_flush_count", 32'(fl_count), 27);
    step(1'b0, 1'b1, 6'd40, 1'b0);
    check("push40_count", 32'(fl_count), 28);
    step(1'b1, 1'b1, 6'd50, 1'b1);
    check("flush_count", 32'(fl_count), 32);
    check("flush_pd", 32'(pd_fl), 34);
    check("flush_empty", 32'(is_empty_fl), 0);
    for (int i = 0; i < 32; i++) begin
      exp_pd = (i < 30) ? 34 + i : ((i == 30) ? 40 : 50);
      check("post_flush_pd", 32'(pd_fl), 32'(exp_pd));
      step(1'b1, 1'b0, '0, 1'b0);
    end
    check("post_flush_empty", 32'(is_empty_fl), 1);

    // Three laps of pop+push recycling to exercise pointer wrap
    do_reset();
    step(1'b1, 1'b0, '0, 1'b0);
    check("lap_start_pd", 32'(pd_fl), 33);
    for (int k = 0; k < 93; k++) begin
      exp_pd = 33 + (k % 31);
      check("lap_pd", 32'(pd_fl), 32'(exp_pd));
      step(1'b1, 1'b1, P_WIDTH'(exp_pd), 1'b0);
      check("lap_count", 32'(fl_count), 31);
    end
    check("lap_err", 32'(err_double_free), 0);

    // Returning a register that is still free
    do_reset();
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 6'd33, 1'b0);
    check("dup_count", 32'(fl_count), 32);
`ifdef FREE_LIST_CHECK_EN
    check("dup_err", 32'(err_double_free), 1);
    step(1'b0, 1'b0, '0, 1'b0);
    check("dup_err_sticky", 32'(err_double_free), 1);
`else
    check("dup_err", 32'(err_double_free), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
